// File: rtl/seven_seg_pkg.sv
// Shared constants and the segment-pattern decoder for the seven-segment scan
// capture block.
//   Patterns are {g,f,e,d,c,b,a} with bit0 = a and a lit segment = 1.
//   seg_to_code returns {err, code[3:0]}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  function automatic logic [4:0] seg_to_code(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      SEG_0:     result = {1'b0, 4'd0};
      SEG_1:     result = {1'b0, 4'd1};
      SEG_2:     result = {1'b0, 4'd2};
      SEG_3:     result = {1'b0, 4'd3};
      SEG_4:     result = {1'b0, 4'd4};
      SEG_5:     result = {1'b0, 4'd5};
      SEG_6:     result = {1'b0, 4'd6};
      SEG_7:     result = {1'b0, 4'd7};
      SEG_8:     result = {1'b0, 4'd8};
      SEG_9:     result = {1'b0, 4'd9};
      SEG_9_ALT: result = {1'b0, 4'd9};
      SEG_BLANK: result = {1'b0, CODE_BLANK};
      default:   result = {1'b1, CODE_ERR};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational decode of one active-high seven-segment pattern.
//   pattern  in  7  segments {g,f,e,d,c,b,a}
//   code     out 4  digit code (F = blank, E = illegal)
//   err      out 1  pattern was not a legal digit or blank
module seven_seg_pattern_decode (
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       err
);
  import seven_seg_pkg::*;

  always_comb begin
    {err, code} = seg_to_code(pattern);
  end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Recovers the digits shown on a time-multiplexed seven-segment display bus.
// Each digit pattern must be seen unchanged for STABLE_CYCLES samples before it
// is captured; once every digit has been captured the frame is offered on a
// valid/ready port. Inputs must already be synchronous to clk.
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   seg_in       in   segments {g,f,e,d,c,b,a}, bit0 = a
//   dig_sel      in   digit select, bit i = digit i (digit 0 rightmost)
//   clear        in   sync: drop partial frame, clear overrun
//   digits_out   out  digit i code at [4i+3:4i]
//   digit_err    out  bit i = digit i pattern was illegal
//   frame_valid  out  digits_out/digit_err hold a complete frame
//   frame_ready  in   consumer accepts the frame
//   overrun      out  sticky: a finished frame was dropped
module seven_seg_scan_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0,
  parameter int STABLE_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);
  import seven_seg_pkg::*;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  logic [6:0]              seg_norm, seg_q, prev_seg;
  logic [NUM_DIGITS-1:0]   dig_norm, dig_q, prev_dig;
  logic                    one_hot, same, capture, complete;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [3:0]              dec_code;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] work_digits;
  logic [NUM_DIGITS-1:0]   work_err, seen, cap_mask;

  always_comb begin
    seg_norm = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
    dig_norm = (DIG_ACTIVE_LOW != 0) ? ~dig_sel : dig_sel;
  end

  // Sample register plus a copy of the previous sample for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      dig_q    <= '0;
      prev_seg <= '0;
      prev_dig <= '0;
    end else begin
      seg_q    <= seg_norm;
      dig_q    <= dig_norm;
      prev_seg <= seg_q;
      prev_dig <= dig_q;
    end
  end

  seven_seg_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (dec_code),
    .err     (dec_err)
  );

  always_comb begin
    one_hot = ($countones(dig_q) == 1);
    same    = (seg_q == prev_seg) && (dig_q == prev_dig);
    idx     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q[i]) idx = IW'(i);
    end

    cnt_nx = '0;
    if (one_hot) begin
      if (!same)               cnt_nx = CW'(1);
      else if (cnt == STABLE_C) cnt_nx = cnt;
      else                     cnt_nx = cnt + CW'(1);
    end

    // Capture only on the transition into saturation; a fresh pattern that
    // restarts the count at 1 also counts as a transition when STABLE_CYCLES==1.
    capture  = one_hot && (cnt_nx == STABLE_C) && !(same && (cnt == STABLE_C));
    cap_mask = capture ? dig_q : '0;
    complete = (seen == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      seen        <= '0;
      work_digits <= '0;
      work_err    <= '0;
      digits_out  <= '1;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      if (clear) begin
        cnt     <= '0;
        seen    <= '0;
        overrun <= 1'b0;
      end else begin
        cnt <= cnt_nx;
        if (capture) begin
          work_digits[4*idx +: 4] <= dec_code;
          work_err[idx]           <= dec_err;
        end
        if (complete) begin
          if (!frame_valid || frame_ready) begin
            digits_out  <= work_digits;
            digit_err   <= work_err;
            frame_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        // A capture landing on the completion edge starts the next frame.
        seen <= (complete ? '0 : seen) | cap_mask;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
module tb_seven_seg_scan_capture;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        clear = 1'b0;
  logic        frame_ready = 1'b0;
  logic [15:0] digits_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        overrun;

  logic [6:0]  seg_in2 = 7'h7F;
  logic [3:0]  dig_sel2 = 4'hF;
  logic        clear2 = 1'b0;
  logic        frame_ready2 = 1'b0;
  logic [15:0] digits_out2;
  logic [3:0]  digit_err2;
  logic        frame_valid2;
  logic        overrun2;

  frame_t sb[$];
  frame_t mon_exp;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_seg_scan_capture #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .clear(clear),
    .digits_out(digits_out), .digit_err(digit_err), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .overrun(overrun)
  );

  seven_seg_scan_capture #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .STABLE_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in2), .dig_sel(dig_sel2), .clear(clear2),
    .digits_out(digits_out2), .digit_err(digit_err2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .overrun(overrun2)
  );

  // Scoreboard: every accepted frame is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame: got digits=%h err=%b, required no frame", digits_out, digit_err);
      end else begin
        mon_exp = sb.pop_front();
        if ({digits_out, digit_err} !== mon_exp) begin
          miscompares++;
          $display("FAIL frame: got digits=%h err=%b, required digits=%h err=%b",
                   digits_out, digit_err, mon_exp.d, mon_exp.e);
        end
      end
    end
  end

  task automatic drive(input int d, input logic [6:0] p, input int n);
    dig_sel = 4'b0001 << d;
    seg_in  = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive2(input int d, input logic [6:0] p, input int n);
    dig_sel2 = ~(4'b0001 << d);
    seg_in2  = ~p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dig_sel = '0;
    seg_in  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (digits_out !== 16'hFFFF) begin miscompares++; $display("FAIL reset_digits: got %h, required ffff", digits_out); end
    if (digit_err !== 4'b0000) begin miscompares++; $display("FAIL reset_err: got %b, required 0000", digit_err); end
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", frame_valid); end
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frame;
    frame_ready = 1'b1;
    sb.push_back('{d: 16'h3450, e: 4'b0000});
    drive(3, 7'h4F, 6);
    drive(2, 7'h66, 6);
    drive(1, 7'h6D, 6);
    drive(0, 7'h3F, 6);
    vectors++;
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b, required 1", frame_valid); end
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
    idle(2);
  endtask

  task automatic test_glitch;
    frame_ready = 1'b1;
    sb.push_back('{d: 16'h6718, e: 4'b0000});
    drive(3, 7'h7D, 6);
    drive(2, 7'h07, 6);
    drive(0, 7'h7F, 6);
    drive(1, 7'h5B, 3);
    drive(1, 7'h06, 2);
    vectors += 2;
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b, required 0", frame_valid); end
    if (dut.seen !== 4'b1101) begin miscompares++; $display("FAIL glitch_seen: got %b, required 1101", dut.seen); end
    drive(1, 7'h06, 4);
    vectors++;
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_capture: got %b, required 1", frame_valid); end
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL glitch_drain: got %0d pending, required 0", sb.size()); end
    idle(2);
  endtask

  task automatic test_illegal_blank;
    frame_ready = 1'b1;
    sb.push_back('{d: 16'h4E1F, e: 4'b0100});
    drive(3, 7'h66, 6);
    drive(2, 7'h49, 6);
    drive(1, 7'h06, 6);
    drive(0, 7'h00, 6);
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL illegal_drain: got %0d pending, required 0", sb.size()); end
    idle(2);
  endtask

  task automatic test_overrun;
    frame_ready = 1'b0;
    sb.push_back('{d: 16'h1230, e: 4'b0000});
    drive(3, 7'h06, 6);
    drive(2, 7'h5B, 6);
    drive(1, 7'h4F, 6);
    drive(0, 7'h3F, 6);
    vectors += 2;
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_first_valid: got %b, required 1", frame_valid); end
    if (digits_out !== 16'h1230) begin miscompares++; $display("FAIL overrun_first_digits: got %h, required 1230", digits_out); end
    drive(3, 7'h7F, 6);
    drive(2, 7'h7F, 6);
    drive(1, 7'h7F, 6);
    drive(0, 7'h7F, 6);
    vectors += 3;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: got %b, required 1", overrun); end
    if (digits_out !== 16'h1230) begin miscompares++; $display("FAIL overrun_frozen: got %h, required 1230", digits_out); end
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_valid: got %b, required 1", frame_valid); end
    idle(1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    vectors += 2;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL clear_overrun: got %b, required 0", overrun); end
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL clear_valid: got %b, required 1", frame_valid); end
    frame_ready = 1'b1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL overrun_drain: got %0d pending, required 0", sb.size()); end
    idle(2);
  endtask

  task automatic test_invalid_select;
    frame_ready = 1'b1;
    dig_sel = 4'b0011;
    seg_in  = 7'h06;
    repeat (10) @(posedge clk);
    #1;
    vectors += 3;
    if (dut.cnt !== '0) begin miscompares++; $display("FAIL multihot_cnt: got %0d, required 0", dut.cnt); end
    if (dut.seen !== 4'b0000) begin miscompares++; $display("FAIL multihot_seen: got %b, required 0000", dut.seen); end
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL multihot_valid: got %b, required 0", frame_valid); end
    dig_sel = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    vectors += 2;
    if (dut.cnt !== '0) begin miscompares++; $display("FAIL zerohot_cnt: got %0d, required 0", dut.cnt); end
    if (dut.seen !== 4'b0000) begin miscompares++; $display("FAIL zerohot_seen: got %b, required 0000", dut.seen); end
    idle(1);
    for (int d = 3; d >= 0; d--) drive2(d, 7'h06, 6);
    vectors += 3;
    if (frame_valid2 !== 1'b1) begin miscompares++; $display("FAIL activelow_valid: got %b, required 1", frame_valid2); end
    if (digits_out2 !== 16'h1111) begin miscompares++; $display("FAIL activelow_digits: got %h, required 1111", digits_out2); end
    if (digit_err2 !== 4'b0000) begin miscompares++; $display("FAIL activelow_err: got %b, required 0000", digit_err2); end
    dig_sel2 = 4'hF;
    seg_in2  = 7'h7F;
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    frame_ready = 1'b0;
    for (int d = 3; d >= 0; d--) drive(d, 7'h66, 6);
    vectors++;
    if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL prereset_valid: got %b, required 1", frame_valid); end
    drive(3, 7'h06, 6);
    drive(2, 7'h06, 6);
    dig_sel = 4'b0010;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (digits_out !== 16'hFFFF) begin miscompares++; $display("FAIL midreset_digits: got %h, required ffff", digits_out); end
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b, required 0", frame_valid); end
    if (digit_err !== 4'b0000) begin miscompares++; $display("FAIL midreset_err: got %b, required 0000", digit_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    frame_ready = 1'b1;
    sb.push_back('{d: 16'h3412, e: 4'b0000});
    drive(1, 7'h06, 6);
    drive(0, 7'h5B, 6);
    idle(2);
    vectors += 2;
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL postreset_partial: got %b, required 0", frame_valid); end
    if (dut.seen !== 4'b0011) begin miscompares++; $display("FAIL postreset_seen: got %b, required 0011", dut.seen); end
    drive(3, 7'h4F, 6);
    drive(2, 7'h66, 6);
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL postreset_drain: got %0d pending, required 0", sb.size()); end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_glitch;
    test_illegal_blank;
    test_overrun;
    test_invalid_select;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
